// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality checks used at accept time.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FAULT,
        DONE
    } state_t;

    function automatic logic op_illegal(input logic is_store, input logic [2:0] op);
        logic bad;
        if (is_store)
            bad = (op > F3_W);
        else
            bad = !(op == F3_B || op == F3_H || op == F3_W || op == F3_BU || op == F3_HU);
        return bad;
    endfunction

    // op[1:0] encodes access size for every legal funct3.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        case (op[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends sub-word loads and merges
// sub-word store data into a word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] st_dat,
    output logic [DATA_W-1:0] ld_val,
    output logic [DATA_W-1:0] st_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];

        case (op)
            F3_B:    ld_val = {{24{byte_v[7]}}, byte_v};
            F3_H:    ld_val = {{16{half_v[15]}}, half_v};
            F3_BU:   ld_val = {24'h0, byte_v};
            F3_HU:   ld_val = {16'h0, half_v};
            default: ld_val = word;
        endcase

        st_word = word;
        case (op[1:0])
            2'b00:   st_word[{off, 3'b000} +: 8]    = st_dat[7:0];
            2'b01:   st_word[{off[1], 4'b0000} +: 16] = st_dat[15:0];
            default: st_word = st_dat;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and a word-wide data memory; sub-word
// stores are done as read-modify-write, sub-word loads are extended here.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        dat_op,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] w_dat,
    output logic              ready,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] r_dat,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_dat,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_r_dat
);

    localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W+1)'(MEM_WORDS) * (DATA_W+1)'(4);

    state_t            state;
    logic              we_q;
    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] w_dat_q;
    logic              acc_fault;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] st_word;

    always_comb begin
        acc_fault = op_illegal(we, dat_op)
                 || misaligned(dat_op, addr[1:0])
                 || ({1'b0, addr} >= ADDR_LIMIT);
    end

    lsu_align u_align (
        .word    (mem_r_dat),
        .off     (off_q),
        .op      (op_q),
        .st_dat  (w_dat_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    // All outputs are registered and updated together with the state, so
    // memory enables follow the state and reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            fault     <= 1'b0;
            r_dat     <= '0;
            mem_addr  <= '0;
            mem_w_dat <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            we_q      <= 1'b0;
            op_q      <= '0;
            off_q     <= '0;
            w_dat_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        op_q     <= dat_op;
                        off_q    <= addr[1:0];
                        w_dat_q  <= w_dat;
                        mem_addr <= {addr[DATA_W-1:2], 2'b00};
                        ready    <= 1'b0;
                        if (acc_fault) begin
                            state <= FAULT;
                        end else if (we && dat_op == F3_W) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_w_dat <= w_dat;
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (we_q) begin
                        mem_w_dat <= st_word;
                        mem_write <= 1'b1;
                        state     <= WR;
                    end else begin
                        r_dat <= ld_val;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WR: begin
                    mem_write <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                FAULT: begin
                    done  <= 1'b1;
                    fault <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    done      <= 1'b0;
                    fault     <= 1'b0;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit placed between the core's execute stage and the word-wide data memory. It accepts one load or store request per transaction, checks alignment and range, and performs sub-word loads by extracting and sign- or zero-extending bytes from the memory word. Because the memory only writes whole words, sub-word stores use a read-modify-write sequence. It drives the memory's `addr`/`w_dat`/`mem_read`/`mem_write` port and consumes its combinational `r_dat`.

## Interface
- `MEM_WORDS`, default 32: memory depth in 32-bit words. Byte addresses ≥ `MEM_WORDS*4` fault.
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: core request. A transfer occurs when `req && ready` at a rising edge.
- `we`  in  1: 1 = store, 0 = load. Sampled at transfer.
- `dat_op`  in  3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr`  in  32: byte address.
- `w_dat`  in  32: store data. Only the low bytes are used for SB/SH.
- `ready`  out  1: the unit is idle and can accept a request.
- `done`  out  1: one-cycle pulse marking transaction completion.
- `fault`  out  1: valid with `done`. Indicates misaligned, out-of-range, or illegal `dat_op`.
- `r_dat`  out  32: load result. Held from `done` until the next accepted load.
- `mem_addr`  out  32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_w_dat`  out  32: word written to memory.
- `mem_read`  out  1: memory read enable.
- `mem_write`  out  1: memory write enable. Committed on the edge ending the WR state.
- `mem_r_dat`  in  32: combinational memory read data.

## Operation
- **IDLE:** `ready`=1. On transfer, latch `we`, `dat_op`, `addr`, `w_dat`. The next state is chosen as follows:
  - FAULT, if `dat_op` is illegal for the direction (load 011/110/111; store ≥011), or the access is misaligned (half with `addr[0]`=1; word with `addr[1:0]`≠0), or `addr` ≥ `MEM_WORDS*4`.
  - RD, for a load, SB, or SH.
  - WR, for SW.
- **RD:** `mem_read`=1.
  - Load: capture the extracted and extended value into `r_dat`, then go to DONE.
  - SB/SH: capture `mem_r_dat` into the merge register, then go to WR.
- **WR:** `mem_write`=1.
  - `mem_w_dat` is the latched `w_dat` for SW.
  - For SB/SH it is the merge register with byte `addr[1:0]` (or half `addr[1]`) replaced by `w_dat[7:0]` / `w_dat[15:0]`.
  - Next state is DONE.
- **FAULT:** no memory enables. Go to DONE with `fault` set.
- **DONE:** `done`=1. `fault` reflects the transaction. Next state is IDLE.
- **Byte order:** little-endian. Byte k = `word[8k+7:8k]`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- `mem_read` and `mem_write` are decoded from the state only. They are never both 1.
- `req` outside IDLE is ignored. There is no queuing.
- A faulting load leaves `r_dat` unchanged.

## Timing
- Accept edge = cycle 0. `done` is asserted in the cycle below:
  - fault: cycle 2
  - SW: cycle 2
  - load: cycle 2
  - SB/SH: cycle 3
- The earliest next accept is the edge after DONE, giving a minimum spacing of 3 or 4 cycles.
- Reset values: state IDLE, `ready`=1, `done`=0, `fault`=0, `r_dat`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_w_dat`=0.
- Reset asserted mid-transaction (including in WR) aborts immediately.
  - `mem_write` drops asynchronously.
  - No partial word is committed unless the WR edge has already occurred.
- `mem_addr` is stable for the whole RD→WR sequence of an RMW.

## Structure
- `lsu_pkg` contains:
  - the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - the state enum (IDLE, RD, WR, FAULT, DONE)
  - the alignment-check function
- One combinational sub-module, `lsu_align`.
  - Inputs: word, byte offset, `dat_op`, store data.
  - Outputs: the extended load value and the merged store word.

## Test plan
- Memory word 0x10 = 0x8899AABB:
  - LB 0x11 → `r_dat`=0xFFFFFFAA
  - LBU 0x13 → 0x00000088
  - LH 0x12 → 0xFFFF8899
  - `done` in cycle 2, `fault`=0
- SB 0x12, `w_dat`=0x123456CC:
  - RD in cycle 1.
  - `mem_write`=1 with `mem_w_dat`=0x88CCAABB in cycle 2.
  - `done` in cycle 3.
  - Word 0x10 afterwards = 0x88CCAABB.
- SW 0x14, 0xDEADBEEF:
  - `mem_read` never asserted.
  - `mem_write` in cycle 1.
  - `done` in cycle 2.
  - LW 0x14 then returns 0xDEADBEEF.
- Faults: each of the following gives `done`+`fault` in cycle 2, no memory enable in any cycle, and `r_dat` retained.
  - LW 0x06
  - LH 0x05
  - SW 0x80 (with `MEM_WORDS`=32)
  - load `dat_op`=011
- Back-to-back: `req` held high for two loads.
  - Second accept occurs the edge after the first `done`.
  - `ready`=0 throughout the intervening cycles.
- Assert `rst_n`=0 during WR of an SH:
  - `mem_write` falls without waiting for a clock.
  - Outputs take reset values.
  - Memory word is unchanged if the reset precedes the WR edge.
  - `ready`=1 after release.
